// File: rtl/mux21_1007.sv
// Registered 2:1 data multiplexer with a saturating select-switch counter.
// Define MUX21_1007_SYNC_SEL_EN to pass s through a 2-flop synchronizer first.
module mux21_1007 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y,
  output logic             sel_q,
  output logic [CNT_W-1:0] switch_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic sel_eff;

`ifdef MUX21_1007_SYNC_SEL_EN
  // s may be asynchronous; two flops give metastability time before use.
  logic [1:0] sel_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_sync <= 2'b00;
    end else begin
      sel_sync <= {sel_sync[0], s};
    end
  end

  assign sel_eff = sel_sync[1];
`else
  assign sel_eff = s;
`endif

  // y uses the select being loaded this edge, so data and select stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y          <= '0;
      sel_q      <= 1'b0;
      switch_cnt <= '0;
    end else begin
      sel_q <= sel_eff;
      if ((sel_eff != sel_q) && (switch_cnt != CNT_MAX)) begin
        switch_cnt <= switch_cnt + CNT_W'(1);
      end
      if (en) begin
        y <= sel_eff ? b : a;
      end
    end
  end

endmodule

// File: tb/tb_mux21_1007.sv
// Self-checking bench for mux21_1007: random and directed stimulus against a
// cycle-level reference model; a second narrow instance exercises saturation.
module tb_mux21_1007;

`ifdef MUX21_1007_SYNC_SEL_EN
  localparam int SEL_LAT = 3;
`else
  localparam int SEL_LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b1;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       s = 1'b0;
  logic [7:0] y;
  logic       sel_q;
  logic [7:0] switch_cnt;
  logic [0:0] y_sat;
  logic       sel_q_sat;
  logic [1:0] cnt_sat;

  int n_checks = 0;
  int n_fail = 0;

  mux21_1007 #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .s(s),
    .y(y), .sel_q(sel_q), .switch_cnt(switch_cnt)
  );

  mux21_1007 #(.WIDTH(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a[0:0]), .b(b[0:0]), .s(s),
    .y(y_sat), .sel_q(sel_q_sat), .switch_cnt(cnt_sat)
  );

  always #5 clk = ~clk;

  // Reference model: select requests travel through a delay line of SEL_LAT
  // edges; every change of the effective select is one switch.
  logic [7:0] m_y = '0;
  logic       m_sel = 1'b0;
  int         m_sw = 0;
  bit         s_hist[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_y = '0;
      m_sel = 1'b0;
      m_sw = 0;
      s_hist.delete();
      for (int i = 0; i < SEL_LAT - 1; i++) s_hist.push_back(1'b0);
    end else begin
      bit eff;
      s_hist.push_back(s);
      eff = s_hist.pop_front();
      if (eff != m_sel) m_sw++;
      m_sel = eff;
      if (en) m_y = eff ? b : a;
    end
  end

  function automatic logic [7:0] exp_cnt();
    return (m_sw > 255) ? 8'd255 : 8'(m_sw);
  endfunction

  function automatic logic [1:0] exp_sat();
    return (m_sw > 3) ? 2'd3 : 2'(m_sw);
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; s = 1'b1; en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (y !== 8'h00 || sel_q !== 1'b0 || switch_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_async: y=%h sel_q=%b cnt=%0d, required y=00 sel_q=0 cnt=0", y, sel_q, switch_cnt);
    end
    n_checks++;
    if (y_sat !== 1'b0 || sel_q_sat !== 1'b0 || cnt_sat !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_async_sat: y=%b sel_q=%b cnt=%0d, required 0 0 0", y_sat, sel_q_sat, cnt_sat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (y !== m_y || sel_q !== m_sel) begin
      n_fail++;
      $display("FAIL reset_release: y=%h sel_q=%b, required y=%h sel_q=%b", y, sel_q, m_y, m_sel);
    end
`ifndef MUX21_1007_SYNC_SEL_EN
    n_checks++;
    if (y !== 8'hFF || sel_q !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_direct: y=%h sel_q=%b, required y=ff sel_q=1", y, sel_q);
    end
`endif
  endtask

  task automatic test_truth_table();
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s = k[2];
      a = {8{k[1]}};
      b = {8{k[0]}};
      tick();
      n_checks++;
      if (y !== m_y || y_sat !== m_y[0:0] || sel_q !== m_sel) begin
        n_fail++;
        $display("FAIL truth_table k=%0d: y=%h y_sat=%b sel_q=%b, required y=%h sel_q=%b",
                 k, y, y_sat, sel_q, m_y, m_sel);
      end
    end
  endtask

  task automatic test_enable_hold();
    en = 1'b1; a = 8'hA5; b = 8'h00; s = 1'b0;
    repeat (SEL_LAT + 1) tick();
    n_checks++;
    if (y !== 8'hA5) begin
      n_fail++;
      $display("FAIL enable_setup: y=%h, required a5", y);
    end
    en = 1'b0; a = 8'h3C; b = 8'hFF; s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (y !== 8'hA5 || sel_q !== m_sel || switch_cnt !== exp_cnt()) begin
        n_fail++;
        $display("FAIL enable_hold c%0d: y=%h sel_q=%b cnt=%0d, required y=a5 sel_q=%b cnt=%0d",
                 i, y, sel_q, switch_cnt, m_sel, exp_cnt());
      end
    end
    en = 1'b1;
    tick();
    n_checks++;
    if (y !== 8'hFF || y !== m_y) begin
      n_fail++;
      $display("FAIL enable_resume: y=%h, required ff (model %h)", y, m_y);
    end
  endtask

  task automatic test_sync_latency();
    en = 1'b1; a = 8'h00; b = 8'hFF; s = 1'b0;
    repeat (SEL_LAT + 1) tick();
    s = 1'b1;
    for (int e = 1; e <= SEL_LAT; e++) begin
      tick();
      n_checks++;
      if (y !== ((e < SEL_LAT) ? 8'h00 : 8'hFF)) begin
        n_fail++;
        $display("FAIL select_latency edge%0d: y=%h, required %h", e, y, (e < SEL_LAT) ? 8'h00 : 8'hFF);
      end
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    s = 1'b0;
    tick();
    for (int i = 0; i < 6 + SEL_LAT - 1; i++) begin
      s = ~s;
      tick();
      n_checks++;
      if (cnt_sat !== exp_sat() || switch_cnt !== exp_cnt()) begin
        n_fail++;
        $display("FAIL saturation c%0d: cnt_sat=%0d cnt=%0d, required %0d %0d",
                 i, cnt_sat, switch_cnt, exp_sat(), exp_cnt());
      end
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    en = 1'b1; a = 8'h11; b = 8'h77; s = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      s = ~s;
      tick();
    end
    repeat (SEL_LAT - 1) tick();
    n_checks++;
    if (switch_cnt !== 8'd5 || y !== 8'h77) begin
      n_fail++;
      $display("FAIL mid_run_setup: cnt=%0d y=%h, required 5 77", switch_cnt, y);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (switch_cnt !== 8'd0 || y !== 8'h00 || sel_q !== 1'b0 || cnt_sat !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_run_reset: cnt=%0d y=%h sel_q=%b cnt_sat=%0d, required 0 00 0 0",
               switch_cnt, y, sel_q, cnt_sat);
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      s = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 3) != 0);
      tick();
      n_checks++;
      if (y !== m_y || sel_q !== m_sel || switch_cnt !== exp_cnt() ||
          y_sat !== m_y[0:0] || cnt_sat !== exp_sat()) begin
        n_fail++;
        $display("FAIL random c%0d: y=%h sel_q=%b cnt=%0d y_sat=%b cnt_sat=%0d, required %h %b %0d %b %0d",
                 i, y, sel_q, switch_cnt, y_sat, cnt_sat, m_y, m_sel, exp_cnt(), m_y[0], exp_sat());
      end
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_enable_hold();
    test_sync_latency();
    test_saturation();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
